// File: rtl/enc_frame_sched_if.sv
// enc_frame_sched_if: requester, encoder and status signals of the frame scheduler.
// master = requesters/encoder side, slave = scheduler.
interface enc_frame_sched_if #(
    parameter int NREQ  = 2,
    parameter int LEN_W = 8
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_i;
    logic [NREQ*LEN_W-1:0] len_i;
    logic [NREQ-1:0]       bit_i;
    logic [NREQ-1:0]       bit_valid_i;
    logic [NREQ-1:0]       bit_ready_o;
    logic [NREQ-1:0]       grant_o;
    logic                  enc_enable_o;
    logic                  enc_d_o;
    logic                  enc_valid_i;
    logic                  done_o;
    logic [ID_W-1:0]       done_id_o;
    logic                  busy_o;
    logic                  err_o;

    modport master (
        output req_i, len_i, bit_i, bit_valid_i, enc_valid_i,
        input  bit_ready_o, grant_o, enc_enable_o, enc_d_o,
        input  done_o, done_id_o, busy_o, err_o
    );

    modport slave (
        input  req_i, len_i, bit_i, bit_valid_i, enc_valid_i,
        output bit_ready_o, grant_o, enc_enable_o, enc_d_o,
        output done_o, done_id_o, busy_o, err_o
    );
endinterface

// File: rtl/enc_frame_sched.sv
// enc_frame_sched: round-robin frame scheduler feeding a shared conv encoder.
// Optional payload stall timeout is enabled by defining ENC_SCHED_TIMEOUT_EN.
module enc_frame_sched #(
    parameter int NREQ  = 2,
    parameter int LEN_W = 8,
    parameter int TAIL  = 2
`ifdef ENC_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input logic clk,
    input logic rst,
    enc_frame_sched_if.slave bus
);
    localparam int ID_W = $clog2(NREQ);
    localparam int CW   = LEN_W + 1;
    localparam int TC_W = $clog2(TAIL + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PAYLOAD, S_TAIL, S_DRAIN, S_DONE
    } state_t;

    state_t          state, state_d;
    logic [ID_W-1:0] owner, owner_d, rr, rr_d, pick;
    logic [ID_W-1:0] done_id, done_id_d;
    logic [LEN_W-1:0] len_q, len_d, pick_len, bcnt, bcnt_d;
    logic [CW-1:0]   tgt, tgt_d, sym, sym_d;
    logic [TC_W-1:0] tcnt, tcnt_d;
    logic [NREQ-1:0] grant, grant_d, rdy, rdy_d;
    logic            en, en_d, dat, dat_d;
    logic            done, done_d, busy, busy_d;
    logic            fed, fed_bit;
`ifdef ENC_SCHED_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0]   stall, stall_d;
    logic            flush, flush_d, err, err_d;
`endif

    // Descending scan so the smallest offset from rr wins.
    always_comb begin
        pick = rr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_i[(int'(rr) + k) % NREQ])
                pick = ID_W'((int'(rr) + k) % NREQ);
        end
    end

    assign pick_len = bus.len_i[int'(pick) * LEN_W +: LEN_W];

    always_comb begin
        state_d   = state;
        owner_d   = owner;
        rr_d      = rr;
        len_d     = len_q;
        tgt_d     = tgt;
        bcnt_d    = bcnt;
        tcnt_d    = tcnt;
        sym_d     = sym;
        grant_d   = grant;
        rdy_d     = rdy;
        en_d      = 1'b0;
        dat_d     = dat;
        done_d    = 1'b0;
        done_id_d = done_id;
        fed       = rdy[owner] & bus.bit_valid_i[owner];
        fed_bit   = bus.bit_i[owner];
`ifdef ENC_SCHED_TIMEOUT_EN
        stall_d = stall;
        flush_d = flush;
        err_d   = err;
        if (flush) begin
            fed     = 1'b1;
            fed_bit = 1'b0;
        end
`endif
        if (state != S_IDLE && bus.enc_valid_i)
            sym_d = sym + 1'b1;
        unique case (state)
            S_IDLE: begin
                sym_d = '0;
                if (|bus.req_i) begin
                    owner_d = pick;
                    len_d   = pick_len;
                    tgt_d   = CW'(pick_len) + CW'(TAIL);
                    bcnt_d  = '0;
                    tcnt_d  = '0;
                    grant_d = NREQ'(1) << pick;
`ifdef ENC_SCHED_TIMEOUT_EN
                    stall_d = '0;
                    flush_d = 1'b0;
                    err_d   = 1'b0;
`endif
                    if (pick_len == '0) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_PAYLOAD;
                        rdy_d   = NREQ'(1) << pick;
                    end
                end
            end
            S_PAYLOAD: begin
                if (fed) begin
                    en_d   = 1'b1;
                    dat_d  = fed_bit;
                    bcnt_d = bcnt + 1'b1;
                    if (bcnt_d == len_q) begin
                        rdy_d   = '0;
                        state_d = S_TAIL;
                    end
                end
`ifdef ENC_SCHED_TIMEOUT_EN
                if (fed) begin
                    stall_d = '0;
                end else if (stall == SW'(TIMEOUT - 1)) begin
                    stall_d = '0;
                    flush_d = 1'b1;
                    err_d   = 1'b1;
                    rdy_d   = '0;
                end else begin
                    stall_d = stall + 1'b1;
                end
`endif
            end
            S_TAIL: begin
                en_d   = 1'b1;
                dat_d  = 1'b0;
                tcnt_d = tcnt + 1'b1;
                if (tcnt == TC_W'(TAIL - 1))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // >= also covers a target already met while in TAIL
                if (sym_d >= tgt) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    done_id_d = owner;
                    grant_d   = '0;
                    rr_d = (owner == ID_W'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            owner   <= '0;
            rr      <= '0;
            len_q   <= '0;
            tgt     <= '0;
            bcnt    <= '0;
            tcnt    <= '0;
            sym     <= '0;
            grant   <= '0;
            rdy     <= '0;
            en      <= 1'b0;
            dat     <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            busy    <= 1'b0;
`ifdef ENC_SCHED_TIMEOUT_EN
            stall   <= '0;
            flush   <= 1'b0;
            err     <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            owner   <= owner_d;
            rr      <= rr_d;
            len_q   <= len_d;
            tgt     <= tgt_d;
            bcnt    <= bcnt_d;
            tcnt    <= tcnt_d;
            sym     <= sym_d;
            grant   <= grant_d;
            rdy     <= rdy_d;
            en      <= en_d;
            dat     <= dat_d;
            done    <= done_d;
            done_id <= done_id_d;
            busy    <= busy_d;
`ifdef ENC_SCHED_TIMEOUT_EN
            stall   <= stall_d;
            flush   <= flush_d;
            err     <= err_d;
`endif
        end
    end

    assign bus.grant_o      = grant;
    assign bus.bit_ready_o  = rdy;
    assign bus.enc_enable_o = en;
    assign bus.enc_d_o      = dat;
    assign bus.done_o       = done;
    assign bus.done_id_o    = done_id;
    assign bus.busy_o       = busy;
`ifdef ENC_SCHED_TIMEOUT_EN
    assign bus.err_o        = err;
`else
    assign bus.err_o        = 1'b0;
`endif
endmodule

// File: tb/tb_enc_frame_sched.sv
// tb_enc_frame_sched: scoreboard bench for the encoder frame scheduler.
// Requester sources and a one-cycle encoder valid model drive the DUT.
module tb_enc_frame_sched;
    localparam int NREQ  = 2;
    localparam int LEN_W = 8;
    localparam int TAIL  = 2;

    typedef struct {logic d; int kind;} ex_t;
    typedef struct {int id; int np; logic err;} fr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    enc_frame_sched_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

    enc_frame_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .TAIL(TAIL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ex_t exq[$];
    fr_t exf[$];
    int  xq[$];

    int          f_len[NREQ][$];
    logic [31:0] f_bits[NREQ][$];
    int          f_mode[NREQ][$];
    int          cnt[NREQ];
    bit          act[NREQ];
    bit          tog;

    int              pc, last_en, last_v, done_n;
    logic [NREQ-1:0] pg;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: stall after 3 bits
    task automatic add_frame(input int r, input int len,
                             input logic [31:0] bits, input int mode);
        ex_t e;
        fr_t f;
        f_len[r].push_back(len);
        f_bits[r].push_back(bits);
        f_mode[r].push_back(mode);
        for (int i = 0; i < len; i++) begin
            e.d = bits[i];
            e.kind = 0;
            if (mode == 2 && i >= 3) begin
                e.d = 1'b0;
                e.kind = (i == 3) ? 2 : 1;
            end
            exq.push_back(e);
        end
        for (int i = 0; i < TAIL; i++) begin
            e.d = 1'b0;
            e.kind = (len == 0 && i == 0) ? 2 : 1;
            exq.push_back(e);
        end
        f.id = r;
        f.np = len + TAIL;
        f.err = (mode == 2);
        exf.push_back(f);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exf.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frames_left", exf.size(), 0);
        chk("pulses_left", exq.size(), 0);
    endtask

    // Requester sources plus encoder model (valid_o = enable_i one cycle late)
    initial begin
        logic [NREQ-1:0] xf;
        logic xen, v;
        bit has;
        bus.req_i = '0;
        bus.len_i = '0;
        bus.bit_i = '0;
        bus.bit_valid_i = '0;
        bus.enc_valid_i = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            xf = bus.bit_valid_i & bus.bit_ready_o;
            xen = bus.enc_enable_o;
            @(posedge clk);
            #1;
            tog = ~tog;
            bus.enc_valid_i = xen & ~rst;
            for (int r = 0; r < NREQ; r++) begin
                if (!rst && xf[r]) begin
                    xq.push_back(cyc - 1);
                    cnt[r]++;
                end
                if (bus.grant_o[r]) act[r] = 1'b1;
                if (bus.done_o && int'(bus.done_id_o) == r && act[r]) begin
                    act[r] = 1'b0;
                    cnt[r] = 0;
                    if (f_len[r].size() > 0) begin
                        f_len[r].delete(0);
                        f_bits[r].delete(0);
                        f_mode[r].delete(0);
                    end
                end
                has = f_len[r].size() > 0;
                bus.req_i[r] = has && !act[r];
                bus.len_i[r*LEN_W +: LEN_W] = has ? LEN_W'(f_len[r][0]) : '0;
                bus.bit_i[r] = has ? f_bits[r][0][cnt[r]] : 1'b0;
                v = has && (cnt[r] < f_len[r][0]);
                if (has && f_mode[r][0] == 1) v = v && tog;
                if (has && f_mode[r][0] == 2) v = v && (cnt[r] < 3);
                bus.bit_valid_i[r] = v;
            end
        end
    end

    // Output monitor / scoreboard
    initial begin
        ex_t e;
        fr_t f;
        pc = 0;
        pg = '0;
        last_en = -10;
        last_v = -10;
        done_n = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("ready_not_owner", bus.bit_ready_o & ~bus.grant_o, 0);
                if (bus.grant_o != '0 && pg == '0) begin
                    if (exf.size() > 0)
                        chk("grant", bus.grant_o, NREQ'(1) << exf[0].id);
                    else
                        chk("grant_extra", bus.grant_o, 0);
                end
                pg = bus.grant_o;
                if (bus.enc_enable_o) begin
                    pc++;
                    if (exq.size() == 0) begin
                        chk("enable_extra", 1, 0);
                    end else begin
                        e = exq.pop_front();
                        chk("enc_d", bus.enc_d_o, e.d);
                        if (e.kind == 0) begin
                            if (xq.size() == 0) chk("enable_no_xfer", 1, 0);
                            else chk("xfer_latency", cyc, xq.pop_front() + 1);
                        end else if (e.kind == 1) begin
                            chk("pulse_gap", cyc, last_en + 1);
                        end
                    end
                    last_en = cyc;
                end
                if (bus.done_o) begin
                    done_n++;
                    if (exf.size() == 0) begin
                        chk("done_extra", 1, 0);
                    end else begin
                        f = exf.pop_front();
                        chk("done_id", bus.done_id_o, f.id);
                        chk("frame_pulses", pc, f.np);
                        chk("done_latency", cyc, last_v + 1);
`ifdef ENC_SCHED_TIMEOUT_EN
                        chk("err", bus.err_o, f.err);
`else
                        chk("err", bus.err_o, 0);
`endif
                    end
                    pc = 0;
                end
                if (bus.enc_valid_i) last_v = cyc;
            end
        end
    end

    initial begin
        int dn;
        int n;
        #1 rst = 1'b1;
        #2;
        chk("reset_outputs", {bus.grant_o, bus.bit_ready_o, bus.enc_enable_o,
            bus.enc_d_o, bus.done_o, bus.done_id_o, bus.busy_o, bus.err_o}, 0);

        // Both requesters pending at reset release: order 0,1,0,1
        add_frame(0, 4, 32'h9, 0);
        add_frame(1, 4, 32'h6, 0);
        add_frame(0, 4, 32'hF, 0);
        add_frame(1, 4, 32'h3, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_done(400);

        add_frame(0, 10, 32'h191, 0);
        wait_done(200);

        add_frame(0, 6, 32'h2D, 1);
        wait_done(200);

        add_frame(1, 0, 32'h0, 0);
        wait_done(100);
        @(negedge clk);
        chk("busy_idle", bus.busy_o, 0);

        for (int i = 0; i < 4; i++) begin
            add_frame(i % 2, $urandom_range(0, 20), $urandom(),
                      $urandom_range(0, 1));
            wait_done(300);
        end

        // Reset in the middle of a payload
        add_frame(0, 10, 32'h2B5, 0);
        n = 0;
        while (pc < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (pc < 4) chk("reset_wait", pc, 4);
        @(posedge clk);
        #2;
        dn = done_n;
        rst = 1'b1;
        #1;
        chk("reset_async", {bus.grant_o, bus.bit_ready_o, bus.enc_enable_o,
            bus.enc_d_o, bus.done_o, bus.done_id_o, bus.busy_o, bus.err_o}, 0);
        exq.delete();
        exf.delete();
        xq.delete();
        for (int r = 0; r < NREQ; r++) begin
            f_len[r].delete();
            f_bits[r].delete();
            f_mode[r].delete();
            act[r] = 1'b0;
            cnt[r] = 0;
        end
        pc = 0;
        pg = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_done_after_reset", done_n, dn);
        add_frame(0, 5, 32'h15, 0);
        wait_done(200);

`ifdef ENC_SCHED_TIMEOUT_EN
        add_frame(0, 8, 32'h7, 2);
        wait_done(300);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach the summary, got %0d expected 0 pending", exf.size());
        $fatal(1);
    end
endmodule

// File: doc/enc_frame_sched.md
Name: enc_frame_sched

Overview:
Frame-level scheduler for the shared convolutional encoder in the Viterbi link.
- Arbitrates NREQ bit-stream requesters round-robin, one whole frame at a time.
- Streams the granted requester's payload bits into the encoder's enable_i/d_in.
- Appends TAIL zero bits so the trellis terminates in state 0.
- Counts the encoder's valid_o symbols and signals frame completion.

Parameters:
NREQ, 2, number of requesters (2..8)
LEN_W, 8, width of per-frame payload length field
TAIL, 2, zero-flush bits appended per frame (= constraint length K-1)
TIMEOUT, 16, stall limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_i  in  NREQ  frame request per requester
len_i  in  NREQ*LEN_W  payload length per requester; slice i = bits [i*LEN_W +: LEN_W]
bit_i  in  NREQ  payload bit per requester
bit_valid_i  in  NREQ  payload bit valid per requester
bit_ready_o  out  NREQ  payload bit ready; only the owner's bit can be high
grant_o  out  NREQ  one-hot owner, held for the whole frame
enc_enable_o  out  1  to encoder enable_i; one pulse per bit fed
enc_d_o  out  1  to encoder d_in
enc_valid_i  in  1  from encoder valid_o
done_o  out  1  one-cycle frame-complete pulse
done_id_o  out  $clog2(NREQ)  owner index of the completed frame
busy_o  out  1  high whenever state is not IDLE
err_o  out  1  timeout flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; RR pointer = 0; all counters = 0.
  - All outputs are 0.
  - The encoder shares rst, so both blocks start from state 0.
- Output registration: every output is registered.
- IDLE:
  - If any req_i is high, pick the first requester at or after the RR pointer (wrapping).
  - Latch owner and len_i[owner]; assert grant_o next cycle; go to PAYLOAD.
  - If len = 0, go straight to TAIL.
- PAYLOAD:
  - bit_ready_o[owner] = 1.
  - A transfer occurs when bit_valid_i[owner] & bit_ready_o[owner].
  - On each transfer, the next cycle has enc_enable_o = 1 and enc_d_o = bit_i[owner]. Latency from transfer to encoder is exactly 1 clock.
  - With no transfer, enc_enable_o = 0 (bubble); enc_d_o holds its last value.
  - After the len-th transfer, bit_ready_o drops in the same edge and the state goes to TAIL.
- TAIL:
  - TAIL consecutive cycles with enc_enable_o = 1 and enc_d_o = 0; no bubbles.
  - Then go to DRAIN.
- Symbol counting (all states except IDLE):
  - sym_cnt (LEN_W+1 bits) increments on each enc_valid_i.
  - The target is len + TAIL, computed at LEN_W+1 bits with no overflow.
- DRAIN:
  - When sym_cnt reaches the target, go to DONE. This also applies if the target was reached during TAIL.
- DONE (one cycle):
  - done_o = 1, done_id_o = owner.
  - grant_o clears; RR pointer = owner+1 mod NREQ.
  - Return to IDLE; a new grant is possible the next cycle.
- Simultaneous requests: resolved strictly by RR order. Dropping req_i mid-frame does not abort the frame.
- Other inputs: enc_valid_i while IDLE is ignored. len_i changes after latching are ignored.
- Reset mid-frame: aborts immediately with no done_o. The partial frame is lost.

Optional Feature:
ENC_SCHED_TIMEOUT_EN
- Defined:
  - A stall counter counts consecutive PAYLOAD cycles without a transfer.
  - At TIMEOUT the block sets err_o (sticky until the next grant).
  - The remaining payload bits are fed as zeros at one per cycle, then TAIL and DRAIN run normally.
  - done_o still pulses.
- Undefined: no counter; err_o is tied 0; the block waits indefinitely for owner bits.

Test Plan:
1. Req0 only, len = 10, bits 1,0,0,0,1,0,0,1,1,0 always valid; encoder connected:
   - exactly 12 enc_enable_o pulses, with enc_d_o = 1,0,0,0,1,0,0,1,1,0,0,0;
   - encoder d_out matches the golden soln.txt;
   - done_o = 1 with done_id_o = 0 one cycle after the 12th enc_valid_i.
2. Req0 and req1 both high at reset release, len 4 each:
   - grant order 0,1,0,1;
   - done_id_o alternates; no enable overlap between frames.
3. Owner bit_valid_i toggles 1,0,1,0:
   - enc_enable_o shows bubbles aligned 1 cycle after each transfer;
   - total pulses still len+TAIL.
4. Req1 with len = 0:
   - exactly 2 zero tail pulses, then done_o with done_id_o = 1.
5. Assert rst during the 5th payload bit:
   - all outputs 0 asynchronously, no done_o;
   - the next request from req0 is served normally.
6. With ENC_SCHED_TIMEOUT_EN, bit_valid_i held 0 for 16 cycles after 3 bits of len = 8:
   - err_o = 1;
   - 5 zero payload pulses plus 2 tail pulses, then done_o.
